// File: rtl/merger_kernel_ctrl_if.sv
// Engine-side bundle of the merger kernel sequencer: start/done pulses plus per-engine slice buses.
// Latency: pure wiring, no storage.
// Backpressure: none; engines acknowledge only through one-cycle done pulses.
interface merger_kernel_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 64,
  parameter int XFER_W = 64
);
  logic [NUM_CH-1:0]        eng_start;
  logic [NUM_CH-1:0]        eng_done;
  logic [NUM_CH*ADDR_W-1:0] eng_src_addr;
  logic [NUM_CH*ADDR_W-1:0] eng_dst_addr;
  logic [NUM_CH*XFER_W-1:0] eng_xfer_size;

  modport master (
    output eng_start, eng_src_addr, eng_dst_addr, eng_xfer_size,
    input  eng_done
  );

  modport slave (
    input  eng_start, eng_src_addr, eng_dst_addr, eng_xfer_size,
    output eng_done
  );
endinterface

// File: rtl/merger_kernel_ctrl.sv
// Multi-pass sequencer: splits the buffer over NUM_CH merger engines and ping-pongs in_ptr/out_ptr per pass.
// Latency: start edge at t -> eng_start at t+1; ap_done one cycle after the final done mask is registered.
// Backpressure: none; a start edge outside IDLE is ignored. Optional MERGER_KERNEL_CTRL_PERF_EN adds perf_cycles.
module merger_kernel_ctrl #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 64,
  parameter int XFER_W = 64,
  parameter int PASS_W = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_ready,
  output logic              ap_idle,
  input  logic [XFER_W-1:0] size,
  input  logic [PASS_W-1:0] num_pass,
  input  logic [ADDR_W-1:0] in_ptr,
  input  logic [ADDR_W-1:0] out_ptr,
  output logic              result_in_b,
`ifdef MERGER_KERNEL_CTRL_PERF_EN
  output logic [63:0]       perf_cycles,
`endif
  merger_kernel_ctrl_if.master eng
);

  localparam int SHIFT = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                ap_start_q;
  logic                start_pulse;
  logic [XFER_W-1:0]   cfg_size;
  logic [PASS_W-1:0]   cfg_num_pass;
  logic [ADDR_W-1:0]   cfg_in, cfg_out;
  logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [NUM_CH-1:0]   done_mask_q, done_mask_d;
  logic                load_cfg, load_bus;

  // Slice values for the next LAUNCH, computed from the pass about to start
  logic [ADDR_W-1:0]        src_base, dst_base;
  logic [XFER_W-1:0]        sz, chunk;
  logic [NUM_CH*ADDR_W-1:0] lau_src, lau_dst;
  logic [NUM_CH*XFER_W-1:0] lau_size;

  assign start_pulse   = ap_start & ~ap_start_q;
  assign ap_done       = (state_q == S_DONE);
  assign ap_ready      = ap_done;
  assign ap_idle       = (state_q == S_IDLE);
  assign eng.eng_start = {NUM_CH{state_q == S_LAUNCH}};

  // Next-state, pass counter and done-mask accumulation
  always_comb begin
    state_d     = state_q;
    pass_cnt_d  = pass_cnt_q;
    done_mask_d = done_mask_q;
    load_cfg    = 1'b0;
    load_bus    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_pulse) begin
          load_cfg    = 1'b1;
          pass_cnt_d  = '0;
          done_mask_d = '0;
          if (num_pass == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_LAUNCH;
            load_bus = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        done_mask_d = done_mask_q | eng.eng_done;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (&done_mask_q) begin
          if (pass_cnt_q == cfg_num_pass - PASS_W'(1)) begin
            state_d = S_DONE;
          end else begin
            pass_cnt_d  = pass_cnt_q + PASS_W'(1);
            done_mask_d = '0;
            state_d     = S_LAUNCH;
            load_bus    = 1'b1;
          end
        end else begin
          done_mask_d = done_mask_q | eng.eng_done;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slice the buffer: equal shifted chunks, last engine takes the remainder
  always_comb begin
    if (load_cfg) begin
      src_base = in_ptr;
      dst_base = out_ptr;
      sz       = size;
    end else begin
      src_base = pass_cnt_d[0] ? cfg_out : cfg_in;
      dst_base = pass_cnt_d[0] ? cfg_in  : cfg_out;
      sz       = cfg_size;
    end
    chunk    = sz >> SHIFT;
    lau_src  = '0;
    lau_dst  = '0;
    lau_size = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      lau_src[i*ADDR_W +: ADDR_W] = src_base + ADDR_W'(chunk) * ADDR_W'(i);
      lau_dst[i*ADDR_W +: ADDR_W] = dst_base + ADDR_W'(chunk) * ADDR_W'(i);
      if (i == NUM_CH - 1)
        lau_size[i*XFER_W +: XFER_W] = sz - chunk * XFER_W'(NUM_CH - 1);
      else
        lau_size[i*XFER_W +: XFER_W] = chunk;
    end
  end

  // State, latched configuration and registered engine buses
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q           <= S_IDLE;
      ap_start_q        <= 1'b0;
      cfg_size          <= '0;
      cfg_num_pass      <= '0;
      cfg_in            <= '0;
      cfg_out           <= '0;
      pass_cnt_q        <= '0;
      done_mask_q       <= '0;
      result_in_b       <= 1'b0;
      eng.eng_src_addr  <= '0;
      eng.eng_dst_addr  <= '0;
      eng.eng_xfer_size <= '0;
    end else begin
      state_q     <= state_d;
      ap_start_q  <= ap_start;
      pass_cnt_q  <= pass_cnt_d;
      done_mask_q <= done_mask_d;
      if (load_cfg) begin
        cfg_size     <= size;
        cfg_num_pass <= num_pass;
        cfg_in       <= in_ptr;
        cfg_out      <= out_ptr;
      end
      if (load_bus) begin
        eng.eng_src_addr  <= lau_src;
        eng.eng_dst_addr  <= lau_dst;
        eng.eng_xfer_size <= lau_size;
      end
      // An even pass count leaves the data back in in_ptr
      if (load_cfg && (num_pass == '0))
        result_in_b <= 1'b0;
      else if ((state_q == S_WAIT) && (state_d == S_DONE))
        result_in_b <= cfg_num_pass[0];
    end
  end

`ifdef MERGER_KERNEL_CTRL_PERF_EN
  // Job-length counter: cleared on an accepted start, counts every non-IDLE cycle
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n)
      perf_cycles <= '0;
    else if ((state_q == S_IDLE) && start_pulse)
      perf_cycles <= '0;
    else if (state_q != S_IDLE)
      perf_cycles <= perf_cycles + 64'd1;
  end
`endif

endmodule

// File: tb/tb_merger_kernel_ctrl.sv
// Directed bench for merger_kernel_ctrl with NUM_CH=4 and 64-bit buses.
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: engines are modelled by hand-placed done pulses.
module tb_merger_kernel_ctrl;
  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_done, ap_ready, ap_idle;
  logic [63:0] size;
  logic [7:0]  num_pass;
  logic [63:0] in_ptr, out_ptr;
  logic        result_in_b;
`ifdef MERGER_KERNEL_CTRL_PERF_EN
  logic [63:0] perf_cycles;
`endif

  int checks = 0;
  int errors = 0;

  merger_kernel_ctrl_if #(.NUM_CH(4), .ADDR_W(64), .XFER_W(64)) eng_if ();

  merger_kernel_ctrl #(.NUM_CH(4), .ADDR_W(64), .XFER_W(64), .PASS_W(8)) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_done     (ap_done),
    .ap_ready    (ap_ready),
    .ap_idle     (ap_idle),
    .size        (size),
    .num_pass    (num_pass),
    .in_ptr      (in_ptr),
    .out_ptr     (out_ptr),
    .result_in_b (result_in_b),
`ifdef MERGER_KERNEL_CTRL_PERF_EN
    .perf_cycles (perf_cycles),
`endif
    .eng         (eng_if.master)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse(input logic [3:0] m);
    eng_if.eng_done = m;
    step();
    eng_if.eng_done = 4'h0;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [255:0] exp_src, exp_dst, exp_sz;
  int done_seen, start_seen;

  initial begin
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    size = 64'd4096;
    num_pass = 8'd1;
    in_ptr = 64'h1000;
    out_ptr = 64'h9000;
    eng_if.eng_done = 4'h0;
    idle_cycles(2);
    check("rst_idle", 256'(ap_idle), 256'(1'b1));
    check("rst_done", 256'(ap_done), 256'(1'b0));
    check("rst_start", 256'(eng_if.eng_start), 256'(4'h0));
    check("rst_src", 256'(eng_if.eng_src_addr), 256'd0);
    check("rst_rib", 256'(result_in_b), 256'(1'b0));
    ap_rst_n = 1'b1;
    step();

    // Job 1: one pass, staggered dones
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    exp_src = {64'h1C00, 64'h1800, 64'h1400, 64'h1000};
    exp_dst = {64'h9C00, 64'h9800, 64'h9400, 64'h9000};
    exp_sz  = {64'd1024, 64'd1024, 64'd1024, 64'd1024};
    check("j1_eng_start", 256'(eng_if.eng_start), 256'(4'hF));
    check("j1_src", eng_if.eng_src_addr, exp_src);
    check("j1_dst", eng_if.eng_dst_addr, exp_dst);
    check("j1_size", eng_if.eng_xfer_size, exp_sz);
    check("j1_busy", 256'(ap_idle), 256'(1'b0));
    idle_cycles(3);
    pulse(4'h1);
    idle_cycles(10);
    pulse(4'h4);
    idle_cycles(5);
    pulse(4'h2);
    idle_cycles(20);
    check("j1_no_early_done", 256'(ap_done), 256'(1'b0));
    pulse(4'h8);
    check("j1_done_lat0", 256'(ap_done), 256'(1'b0));
    step();
    check("j1_done", 256'(ap_done), 256'(1'b1));
    check("j1_ready", 256'(ap_ready), 256'(1'b1));
    check("j1_rib", 256'(result_in_b), 256'(1'b1));
    step();
    check("j1_back_idle", 256'(ap_idle), 256'(1'b1));
    check("j1_done_pulse", 256'(ap_done), 256'(1'b0));

    // Job 2: three passes ping-pong
    num_pass = 8'd3;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    check("j2_p0_src", 256'(eng_if.eng_src_addr[63:0]), 256'(64'h1000));
    pulse(4'hF);
    step();
    check("j2_p1_start", 256'(eng_if.eng_start), 256'(4'hF));
    check("j2_p1_src0", 256'(eng_if.eng_src_addr[63:0]), 256'(64'h9000));
    check("j2_p1_dst0", 256'(eng_if.eng_dst_addr[63:0]), 256'(64'h1000));
    check("j2_p1_src3", 256'(eng_if.eng_src_addr[255:192]), 256'(64'h9C00));
    pulse(4'hF);
    step();
    check("j2_p2_start", 256'(eng_if.eng_start), 256'(4'hF));
    check("j2_p2_src0", 256'(eng_if.eng_src_addr[63:0]), 256'(64'h1000));
    pulse(4'hF);
    step();
    check("j2_done", 256'(ap_done), 256'(1'b1));
    check("j2_rib", 256'(result_in_b), 256'(1'b1));
    step();
`ifdef MERGER_KERNEL_CTRL_PERF_EN
    check("j2_perf", 256'(perf_cycles), 256'(64'd7));
`endif

    // Job 3: two passes end in in_ptr
    num_pass = 8'd2;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    pulse(4'hF);
    step();
    pulse(4'hF);
    step();
    check("j3_done", 256'(ap_done), 256'(1'b1));
    check("j3_rib", 256'(result_in_b), 256'(1'b0));
    step();

    // Job 4: remainder slice, duplicate done, mid-WAIT start edge
    num_pass = 8'd1;
    size = 64'd4099;
    in_ptr = 64'h0;
    ap_start = 1'b1;
    step();
    exp_sz = {64'd1027, 64'd1024, 64'd1024, 64'd1024};
    check("j4_size", eng_if.eng_xfer_size, exp_sz);
    check("j4_last_off", 256'(eng_if.eng_src_addr[255:192]), 256'(64'hC00));
    pulse(4'h1);
    pulse(4'h1);
    ap_start = 1'b0;
    step();
    ap_start = 1'b1;
    step();
    pulse(4'h2);
    pulse(4'h4);
    step();
    check("j4_wait_ch3", 256'(ap_done), 256'(1'b0));
    check("j4_still_busy", 256'(ap_idle), 256'(1'b0));
    check("j4_no_relaunch", 256'(eng_if.eng_start), 256'(4'h0));
    pulse(4'h8);
    step();
    check("j4_done", 256'(ap_done), 256'(1'b1));
    idle_cycles(3);
    check("j4_level_no_retrig", 256'(ap_idle), 256'(1'b1));

    // Job 5: zero passes, start held for 20 cycles
    ap_start = 1'b0;
    num_pass = 8'd0;
    step();
    ap_start = 1'b1;
    done_seen = 0;
    start_seen = 0;
    step();
    check("j5_done_t1", 256'(ap_done), 256'(1'b1));
    check("j5_rib", 256'(result_in_b), 256'(1'b0));
    for (int k = 0; k < 20; k++) begin
      if (ap_done) done_seen++;
      if (eng_if.eng_start != 4'h0) start_seen++;
      step();
    end
    check("j5_one_job", 256'(done_seen), 256'(1));
    check("j5_no_eng_start", 256'(start_seen), 256'(0));
`ifdef MERGER_KERNEL_CTRL_PERF_EN
    check("j5_perf", 256'(perf_cycles), 256'(64'd1));
`endif

    // Job 6: reset pulse mid-WAIT
    ap_start = 1'b0;
    num_pass = 8'd1;
    size = 64'd4096;
    in_ptr = 64'h1000;
    step();
    ap_start = 1'b1;
    step();
    step();
    pulse(4'h3);
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    step();
    check("j6_rst_idle", 256'(ap_idle), 256'(1'b1));
    check("j6_rst_start", 256'(eng_if.eng_start), 256'(4'h0));
    check("j6_rst_src", 256'(eng_if.eng_src_addr), 256'd0);
    check("j6_rst_rib", 256'(result_in_b), 256'(1'b0));
    ap_rst_n = 1'b1;
    done_seen = 0;
    pulse(4'hC);
    for (int k = 0; k < 5; k++) begin
      if (ap_done) done_seen++;
      step();
    end
    check("j6_no_done", 256'(done_seen), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
